// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// Grants are registered; y/v mirror the one-hot grant as an encoded index
// plus valid flag. A holder keeps the resource until it drops its request
// or until it has held for MAX_HOLD cycles while someone else is waiting.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] y,
  output logic       v
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    y_q, y_d;
  logic          v_q, v_d;

  logic [2:0]    pick_all;    // {found, index} over the full request vector
  logic [2:0]    pick_other;  // {found, index} with the current holder masked

  // Scan ptr+1 .. ptr+4 (mod 4) and return the first requesting index.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = p + 2'(k);
      if (!res[2] && r[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  // Candidate winners for a fresh search and for a handoff away from the holder.
  always_comb begin
    pick_all   = rr_pick(req, ptr_q);
    pick_other = rr_pick(req & ~gnt_q, ptr_q);
  end

  // Next-state logic: idle search, release handoff, forced rotation, hold.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    y_d        = y_q;
    v_d        = v_q;
    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d    = GRANT;
          ptr_d      = pick_all[1:0];
          hold_cnt_d = '0;
          gnt_d      = 4'b0001 << pick_all[1:0];
          y_d        = pick_all[1:0];
          v_d        = 1'b1;
        end
      end
      GRANT: begin
        if (!req[y_q] || (hold_cnt_q == HOLD_LAST && pick_other[2])) begin
          // Holder released, or its hold budget ran out with others waiting.
          if (pick_other[2]) begin
            ptr_d      = pick_other[1:0];
            hold_cnt_d = '0;
            gnt_d      = 4'b0001 << pick_other[1:0];
            y_d        = pick_other[1:0];
            v_d        = 1'b1;
          end else begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            gnt_d      = 4'b0000;
            y_d        = 2'b00;
            v_d        = 1'b0;
          end
        end else if (hold_cnt_q != HOLD_LAST) begin
          // Saturating count lets a lone requester hold indefinitely.
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
        gnt_d      = 4'b0000;
        y_d        = 2'b00;
        v_d        = 1'b0;
      end
    endcase
  end

  // State and registered outputs; asynchronous reset clears outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'b11;
      hold_cnt_q <= '0;
      gnt_q      <= 4'b0000;
      y_q        <= 2'b00;
      v_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      y_q        <= y_d;
      v_q        <= v_d;
    end
  end

  assign gnt = gnt_q;
  assign y   = y_q;
  assign v   = v_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: directed scenarios plus randomized
// traffic compared against a behavioural round-robin model.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] y;
  logic       v;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the resource (-1 = nobody), last winner, hold age.
  int m_holder;
  int m_ptr;
  int m_cnt;

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .y     (y),
    .v     (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rr_search(input logic [3:0] r, input int p, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (i != excl && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 3;
    m_cnt    = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    if (m_holder < 0) begin
      w = rr_search(r, m_ptr, -1);
      if (w >= 0) begin m_holder = w; m_ptr = w; m_cnt = 0; end
    end else if (!r[m_holder] || (m_cnt == MAX_HOLD - 1 && rr_search(r, m_ptr, m_holder) >= 0)) begin
      w = rr_search(r, m_ptr, m_holder);
      if (w >= 0) begin m_holder = w; m_ptr = w; m_cnt = 0; end
      else begin m_holder = -1; m_cnt = 0; end
    end else if (m_cnt < MAX_HOLD - 1) begin
      m_cnt = m_cnt + 1;
    end
  endtask

  // Expected {gnt, y, v} from the model.
  function automatic logic [6:0] model_out();
    if (m_holder < 0) return 7'b0;
    return {4'(1 << m_holder), 2'(m_holder), 1'b1};
  endfunction

  // Apply req, advance one rising edge, update the model, settle 1 ns.
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({gnt, y, v} !== 7'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got gnt=%b y=%b v=%b want 0000/00/0", i, gnt, y, v);
      end
    end
    rst_n = 1'b1;
    cycle(4'b1111);
    checks++;
    if ({gnt, y, v} !== {4'b0001, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL reset_release got gnt=%b y=%b v=%b want 0001/00/1", gnt, y, v);
    end
    $display("reset: release grant gnt=%b y=%b v=%b", gnt, y, v);
  endtask

  task automatic test_fairness();
    int h;
    do_reset();
    cycle(4'b1111);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({gnt, y, v} !== {4'(1 << (k % 4)), 2'(k % 4), 1'b1}) begin
        errors++;
        $display("FAIL fairness_order k=%0d got gnt=%b y=%b v=%b want idx %0d", k, gnt, y, v, k % 4);
      end
      $display("fairness: grant %0d -> gnt=%b y=%b", k, gnt, y);
      h = int'(y);
      cycle(4'b1111);
      cycle(4'b1111 & ~4'(1 << h));
    end
  endtask

  task automatic test_forced_rotation();
    logic [3:0] exp_g;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      cycle(4'b0011);
      exp_g = ((i / MAX_HOLD) % 2 == 0) ? 4'b0001 : 4'b0010;
      checks++;
      if (gnt !== exp_g || {gnt, y, v} !== model_out()) begin
        errors++;
        $display("FAIL forced_rot cyc=%0d got gnt=%b want %b", i, gnt, exp_g);
      end
    end
    $display("forced rotation: 24 cycles of req=0011 checked");
  endtask

  task automatic test_lone_holder();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0100);
      checks++;
      if ({gnt, y, v} !== {4'b0100, 2'b10, 1'b1}) begin
        errors++;
        $display("FAIL lone_hold cyc=%0d got gnt=%b y=%b v=%b want 0100/10/1", i, gnt, y, v);
      end
    end
    cycle(4'b0000);
    checks++;
    if ({gnt, y, v} !== 7'b0) begin
      errors++;
      $display("FAIL lone_release got gnt=%b y=%b v=%b want 0000/00/0", gnt, y, v);
    end
    $display("lone holder: released gnt=%b v=%b", gnt, v);
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(4'b1000);
    cycle(4'b0000);
    cycle(4'b1001);
    checks++;
    if ({gnt, y, v} !== {4'b0001, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL wrap_to_0 got gnt=%b y=%b v=%b want 0001/00/1", gnt, y, v);
    end
    cycle(4'b1000);
    checks++;
    if ({gnt, y, v} !== {4'b1000, 2'b11, 1'b1}) begin
      errors++;
      $display("FAIL wrap_to_3 got gnt=%b y=%b v=%b want 1000/11/1", gnt, y, v);
    end
    $display("wrap: final gnt=%b y=%b", gnt, y);
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(4'b0100);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL async_pre got gnt=%b want 0100", gnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, y, v} !== 7'b0) begin
      errors++;
      $display("FAIL async_clear got gnt=%b y=%b v=%b want 0000/00/0", gnt, y, v);
    end
    #2;
    rst_n = 1'b1;
    model_reset();
    cycle(4'b0100);
    checks++;
    if ({gnt, y, v} !== {4'b0100, 2'b10, 1'b1}) begin
      errors++;
      $display("FAIL async_regrant got gnt=%b y=%b v=%b want 0100/10/1", gnt, y, v);
    end
    // A fresh search from ptr=3 with all four requesting must pick index 0.
    do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cycle(4'b1111);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL async_ptr got gnt=%b want 0001", gnt);
    end
    $display("async reset: regrant gnt=%b", gnt);
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      cycle(r);
      checks++;
      if ({gnt, y, v} !== model_out() || !$onehot0(gnt)) begin
        errors++;
        $display("FAIL random cyc=%0d req=%b got gnt=%b y=%b v=%b want %b", i, r, gnt, y, v, model_out());
      end
    end
    $display("random: 400 cycles compared against model");
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    test_reset();
    test_fairness();
    test_forced_rotation();
    test_lone_holder();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
